// File: rtl/sim_ctrl_pkg.sv
// Shared types for the simulation end-of-test controller.
package sim_ctrl_pkg;

  // Reported outcome of a simulation run.
  typedef enum logic [1:0] {
    RUNNING = 2'd0,
    PASS    = 2'd1,
    FAIL    = 2'd2,
    TIMEOUT = 2'd3
  } sim_status_t;

  // Controller state.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } sim_state_t;

endpackage : sim_ctrl_pkg

// File: rtl/sim_finish_controller.sv
// End-of-simulation controller: records per-source finish/fail flags, combines
// the finish flags in ALL or ANY mode, waits a drain period, then raises a
// sticky finish with PASS/FAIL/TIMEOUT status. A watchdog bounds the run.
//
// Ports:
//   sys_clk      - single clock
//   sys_rst      - synchronous, active-high reset
//   src_finish   - per-source finish flags (level or pulse)
//   src_fail     - per-source failure flags (level or pulse)
//   src_seen     - sticky record of src_finish
//   fail_seen    - sticky record of src_fail
//   finish       - sticky, high once DONE is reached
//   status       - 0 RUNNING, 1 PASS, 2 FAIL, 3 TIMEOUT
//   cycle_count  - cycles since reset, saturating, frozen in DONE
module sim_finish_controller
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC          = 2,
  parameter bit          MODE_ALL       = 1'b1,
  parameter int unsigned DRAIN_CYCLES   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [N_SRC-1:0] src_finish,
  input  logic [N_SRC-1:0] src_fail,
  output logic [N_SRC-1:0] src_seen,
  output logic [N_SRC-1:0] fail_seen,
  output logic             finish,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam bit          WDOG_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0]   WDOG_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

  sim_state_t         state_q, state_nxt;
  sim_status_t        status_q, status_nxt;
  logic [DRAIN_W-1:0] drain_cnt, drain_cnt_nxt;
  logic [N_SRC-1:0]   src_seen_nxt, fail_seen_nxt;
  logic [N_SRC-1:0]   fin_c, fail_c;
  logic [CNT_W-1:0]   cycle_count_nxt, cnt_inc;
  logic               finish_nxt;
  logic               trigger;

  // Only an explicit 1 counts; X or Z inputs are treated as not asserted.
  always_comb begin
    fin_c  = '0;
    fail_c = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (src_finish[i] == 1'b1) fin_c[i] = 1'b1;
      if (src_fail[i] == 1'b1)   fail_c[i] = 1'b1;
    end
  end

  // Saturating cycle counter increment.
  assign cnt_inc = (cycle_count == {CNT_W{1'b1}}) ? cycle_count : cycle_count + CNT_W'(1);

  // Next-state and output logic.
  always_comb begin
    state_nxt       = state_q;
    status_nxt      = status_q;
    drain_cnt_nxt   = drain_cnt;
    src_seen_nxt    = src_seen;
    fail_seen_nxt   = fail_seen;
    cycle_count_nxt = cycle_count;
    finish_nxt      = finish;
    trigger         = 1'b0;

    case (state_q)
      RUN: begin
        src_seen_nxt    = src_seen | fin_c;
        fail_seen_nxt   = fail_seen | fail_c;
        cycle_count_nxt = cnt_inc;
        trigger         = MODE_ALL ? (&src_seen_nxt) : (|src_seen_nxt);
        // Trigger takes priority over a coincident watchdog expiry.
        if (trigger) begin
          if (DRAIN_CYCLES > 0) begin
            state_nxt     = DRAIN;
            drain_cnt_nxt = DRAIN_LOAD;
          end else begin
            state_nxt  = DONE;
            finish_nxt = 1'b1;
            status_nxt = (|fail_seen_nxt) ? FAIL : PASS;
          end
        end else if (WDOG_EN && (cycle_count == WDOG_LAST)) begin
          state_nxt  = DONE;
          finish_nxt = 1'b1;
          status_nxt = TIMEOUT;
        end
      end

      DRAIN: begin
        src_seen_nxt    = src_seen | fin_c;
        fail_seen_nxt   = fail_seen | fail_c;
        cycle_count_nxt = cnt_inc;
        drain_cnt_nxt   = drain_cnt - DRAIN_W'(1);
        if (drain_cnt == DRAIN_W'(1)) begin
          state_nxt  = DONE;
          finish_nxt = 1'b1;
          status_nxt = (|fail_seen_nxt) ? FAIL : PASS;
        end
      end

      DONE: begin
        state_nxt = DONE;
      end

      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= RUN;
      status_q    <= RUNNING;
      drain_cnt   <= '0;
      src_seen    <= '0;
      fail_seen   <= '0;
      cycle_count <= '0;
      finish      <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      status_q    <= status_nxt;
      drain_cnt   <= drain_cnt_nxt;
      src_seen    <= src_seen_nxt;
      fail_seen   <= fail_seen_nxt;
      cycle_count <= cycle_count_nxt;
      finish      <= finish_nxt;
    end
  end

  assign status = status_q;

endmodule : sim_finish_controller

// File: tb/tb_sim_finish_controller.sv
// Directed bench for sim_finish_controller. "Period n" is the interval after
// the n-th rising edge following reset release; inputs are driven and outputs
// sampled on the falling edge inside that period.
module tb_sim_finish_controller;

  logic clk = 1'b0;
  logic sys_rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sys_rst) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // a: ALL mode, drain 4
  logic [1:0] fin_a, fail_a, seen_a, fseen_a, status_a;
  logic finish_a;
  logic [31:0] cnt_a;
  // b: ANY mode, drain 4
  logic [1:0] fin_b, fail_b, seen_b, fseen_b, status_b;
  logic finish_b;
  logic [31:0] cnt_b;
  // t: watchdog 100
  logic [1:0] fin_t, fail_t, seen_t, fseen_t, status_t;
  logic finish_t;
  logic [31:0] cnt_t;
  // z: watchdog 50, drain 0
  logic [1:0] fin_z, fail_z, seen_z, fseen_z, status_z;
  logic finish_z;
  logic [31:0] cnt_z;
  // d: watchdog 50, drain 40
  logic [1:0] fin_d, fail_d, seen_d, fseen_d, status_d;
  logic finish_d;
  logic [31:0] cnt_d;
  // s: 4-bit counter, watchdog disabled
  logic [1:0] fin_s, fail_s, seen_s, fseen_s, status_s;
  logic finish_s;
  logic [3:0] cnt_s;

  sim_finish_controller #(.N_SRC(2), .MODE_ALL(1'b1), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(1000), .CNT_W(32)) u_a (
    .sys_clk(clk), .sys_rst(sys_rst), .src_finish(fin_a), .src_fail(fail_a), .src_seen(seen_a),
    .fail_seen(fseen_a), .finish(finish_a), .status(status_a), .cycle_count(cnt_a));
  sim_finish_controller #(.N_SRC(2), .MODE_ALL(1'b0), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(1000), .CNT_W(32)) u_b (
    .sys_clk(clk), .sys_rst(sys_rst), .src_finish(fin_b), .src_fail(fail_b), .src_seen(seen_b),
    .fail_seen(fseen_b), .finish(finish_b), .status(status_b), .cycle_count(cnt_b));
  sim_finish_controller #(.N_SRC(2), .MODE_ALL(1'b1), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(100), .CNT_W(32)) u_t (
    .sys_clk(clk), .sys_rst(sys_rst), .src_finish(fin_t), .src_fail(fail_t), .src_seen(seen_t),
    .fail_seen(fseen_t), .finish(finish_t), .status(status_t), .cycle_count(cnt_t));
  sim_finish_controller #(.N_SRC(2), .MODE_ALL(1'b1), .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(50), .CNT_W(32)) u_z (
    .sys_clk(clk), .sys_rst(sys_rst), .src_finish(fin_z), .src_fail(fail_z), .src_seen(seen_z),
    .fail_seen(fseen_z), .finish(finish_z), .status(status_z), .cycle_count(cnt_z));
  sim_finish_controller #(.N_SRC(2), .MODE_ALL(1'b1), .DRAIN_CYCLES(40), .TIMEOUT_CYCLES(50), .CNT_W(32)) u_d (
    .sys_clk(clk), .sys_rst(sys_rst), .src_finish(fin_d), .src_fail(fail_d), .src_seen(seen_d),
    .fail_seen(fseen_d), .finish(finish_d), .status(status_d), .cycle_count(cnt_d));
  sim_finish_controller #(.N_SRC(2), .MODE_ALL(1'b1), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(0), .CNT_W(4)) u_s (
    .sys_clk(clk), .sys_rst(sys_rst), .src_finish(fin_s), .src_fail(fail_s), .src_seen(seen_s),
    .fail_seen(fseen_s), .finish(finish_s), .status(status_s), .cycle_count(cnt_s));

  task automatic clear_inputs();
    fin_a = '0; fail_a = '0; fin_b = '0; fail_b = '0; fin_t = '0; fail_t = '0;
    fin_z = '0; fail_z = '0; fin_d = '0; fail_d = '0; fin_s = '0; fail_s = '0;
  endtask

  // Leaves the bench at the falling edge of period 0.
  task automatic reset_dut();
    @(negedge clk);
    sys_rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    sys_rst = 1'b0;
  endtask

  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if ({seen_a, fseen_a, finish_a, status_a, cnt_a} !== 39'd0) begin
      errors++; $display("FAIL reset_a: got %h want 0", {seen_a, fseen_a, finish_a, status_a, cnt_a});
    end
    checks++;
    if ({seen_b, fseen_b, finish_b, status_b, cnt_b, seen_s, fseen_s, finish_s, status_s, cnt_s} !== 50'd0) begin
      errors++; $display("FAIL reset_bs: got %h want 0", {seen_b, fseen_b, finish_b, status_b, cnt_b, seen_s, fseen_s, finish_s, status_s, cnt_s});
    end
    checks++;
    if ({finish_t, status_t, cnt_t, finish_z, status_z, cnt_z, finish_d, status_d, cnt_d} !== 105'd0) begin
      errors++; $display("FAIL reset_tzd: got %h want 0", {finish_t, status_t, cnt_t, finish_z, status_z, cnt_z, finish_d, status_d, cnt_d});
    end
  endtask

  task automatic test_all_mode();
    reset_dut();
    goto(10); fin_a[0] = 1'b1;
    goto(11); fin_a[0] = 1'b0;
    checks++;
    if (seen_a !== 2'b01) begin errors++; $display("FAIL all_seen_pulse: got %b want 01", seen_a); end
    goto(20); fin_a[1] = 1'b1;
    checks++;
    if (finish_a !== 1'b0) begin errors++; $display("FAIL all_no_finish_20: got %b want 0", finish_a); end
    goto(21);
    checks++;
    if ({seen_a, finish_a} !== 3'b110) begin errors++; $display("FAIL all_seen_21: got %b want 110", {seen_a, finish_a}); end
    goto(24);
    checks++;
    if ({finish_a, status_a} !== 3'b000) begin errors++; $display("FAIL all_drain_24: got %b want 000", {finish_a, status_a}); end
    goto(25);
    checks++;
    if ({finish_a, status_a} !== 3'b101) begin errors++; $display("FAIL all_finish_25: got %b want 101", {finish_a, status_a}); end
    checks++;
    if (cnt_a !== 32'd25) begin errors++; $display("FAIL all_count_25: got %0d want 25", cnt_a); end
    goto(28);
    checks++;
    if ({cnt_a, finish_a} !== {32'd25, 1'b1}) begin errors++; $display("FAIL all_frozen: got cnt %0d fin %b want 25 1", cnt_a, finish_a); end
  endtask

  task automatic test_any_mode();
    reset_dut();
    goto(7); fin_b[1] = 1'b1;
    goto(8); fin_b[1] = 1'b0;
    checks++;
    if (seen_b !== 2'b10) begin errors++; $display("FAIL any_seen_8: got %b want 10", seen_b); end
    goto(11);
    checks++;
    if (finish_b !== 1'b0) begin errors++; $display("FAIL any_no_finish_11: got %b want 0", finish_b); end
    goto(12);
    checks++;
    if ({finish_b, status_b, seen_b} !== 5'b10110) begin errors++; $display("FAIL any_finish_12: got %b want 10110", {finish_b, status_b, seen_b}); end
    goto(14); fin_b[0] = 1'b1;
    goto(15); fin_b[0] = 1'b0;
    goto(16);
    checks++;
    if (seen_b !== 2'b10) begin errors++; $display("FAIL any_seen_frozen: got %b want 10", seen_b); end
  endtask

  task automatic test_fail_status();
    reset_dut();
    goto(15); fail_a[0] = 1'b1;
    goto(16); fail_a[0] = 1'b0;
    checks++;
    if ({fseen_a, finish_a, status_a} !== 5'b01000) begin errors++; $display("FAIL fail_capture_16: got %b want 01000", {fseen_a, finish_a, status_a}); end
    goto(30); fin_a = 2'b11;
    goto(31); fin_a = 2'b00;
    goto(34);
    checks++;
    if (finish_a !== 1'b0) begin errors++; $display("FAIL fail_no_finish_34: got %b want 0", finish_a); end
    goto(35);
    checks++;
    if ({finish_a, status_a, fseen_a} !== 5'b11001) begin errors++; $display("FAIL fail_finish_35: got %b want 11001", {finish_a, status_a, fseen_a}); end
    goto(40); fail_a[1] = 1'b1;
    goto(41); fail_a[1] = 1'b0;
    checks++;
    if ({fseen_a, status_a} !== 4'b0110) begin errors++; $display("FAIL fail_late_ignored: got %b want 0110", {fseen_a, status_a}); end
  endtask

  task automatic test_timeout();
    reset_dut();
    goto(50); fail_t[0] = 1'b1;
    goto(51); fail_t[0] = 1'b0;
    goto(99);
    checks++;
    if ({finish_t, status_t, cnt_t} !== {1'b0, 2'd0, 32'd99}) begin errors++; $display("FAIL wdog_99: got fin %b st %0d cnt %0d want 0 0 99", finish_t, status_t, cnt_t); end
    goto(100);
    checks++;
    if ({finish_t, status_t, cnt_t} !== {1'b1, 2'd3, 32'd100}) begin errors++; $display("FAIL wdog_100: got fin %b st %0d cnt %0d want 1 3 100", finish_t, status_t, cnt_t); end
    goto(104);
    checks++;
    if ({cnt_t, status_t} !== {32'd100, 2'd3}) begin errors++; $display("FAIL wdog_frozen: got cnt %0d st %0d want 100 3", cnt_t, status_t); end
  endtask

  task automatic test_trigger_vs_timeout();
    reset_dut();
    goto(30); fin_d = 2'b11;
    goto(31); fin_d = 2'b00;
    goto(49); fin_z = 2'b11;
    checks++;
    if ({finish_z, finish_d} !== 2'b00) begin errors++; $display("FAIL race_49: got %b want 00", {finish_z, finish_d}); end
    goto(50); fin_z = 2'b00;
    checks++;
    if ({finish_z, status_z, cnt_z} !== {1'b1, 2'd1, 32'd50}) begin errors++; $display("FAIL race_trigger_wins: got fin %b st %0d cnt %0d want 1 1 50", finish_z, status_z, cnt_z); end
    checks++;
    if ({finish_d, status_d} !== 3'b000) begin errors++; $display("FAIL drain_no_wdog_50: got %b want 000", {finish_d, status_d}); end
    goto(70);
    checks++;
    if (finish_d !== 1'b0) begin errors++; $display("FAIL drain40_70: got %b want 0", finish_d); end
    goto(71);
    checks++;
    if ({finish_d, status_d, cnt_d} !== {1'b1, 2'd1, 32'd71}) begin errors++; $display("FAIL drain40_71: got fin %b st %0d cnt %0d want 1 1 71", finish_d, status_d, cnt_d); end
  endtask

  task automatic test_reset_mid_drain();
    reset_dut();
    goto(20); fin_a = 2'b11;
    goto(21); fin_a = 2'b00;
    goto(23);
    sys_rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    checks++;
    if ({seen_a, fseen_a, finish_a, status_a, cnt_a} !== 39'd0) begin
      errors++; $display("FAIL mid_drain_reset: got %h want 0", {seen_a, fseen_a, finish_a, status_a, cnt_a});
    end
    sys_rst = 1'b0;
    goto(5); fin_a = 2'b11;
    goto(6); fin_a = 2'b00;
    goto(9);
    checks++;
    if (finish_a !== 1'b0) begin errors++; $display("FAIL redrain_9: got %b want 0", finish_a); end
    goto(10);
    checks++;
    if ({finish_a, status_a, cnt_a} !== {1'b1, 2'd1, 32'd10}) begin errors++; $display("FAIL redrain_10: got fin %b st %0d cnt %0d want 1 1 10", finish_a, status_a, cnt_a); end
  endtask

  task automatic test_saturation();
    reset_dut();
    goto(14);
    checks++;
    if (cnt_s !== 4'd14) begin errors++; $display("FAIL sat_14: got %0d want 14", cnt_s); end
    goto(15);
    checks++;
    if (cnt_s !== 4'd15) begin errors++; $display("FAIL sat_15: got %0d want 15", cnt_s); end
    goto(22);
    checks++;
    if ({cnt_s, finish_s, status_s} !== {4'd15, 1'b0, 2'd0}) begin errors++; $display("FAIL sat_hold: got cnt %0d fin %b st %0d want 15 0 0", cnt_s, finish_s, status_s); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_all_mode();
    test_any_mode();
    test_fail_status();
    test_timeout();
    test_trigger_vs_timeout();
    test_reset_mid_drain();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL time_limit: got no completion want completion");
    $fatal(1, "time limit");
  end

endmodule : tb_sim_finish_controller

// File: doc/sim_finish_controller.md
# sim_finish_controller

Parametrised end-of-simulation controller for the tester simulation harnesses. It collects per-channel finish and fail flags (for example DDR5 subchannels A/B, BIST engines or the Ethernet bench) and combines them in ALL or ANY mode. After a drain period it raises a sticky finish with a pass/fail/timeout status, and a watchdog guarantees termination. The simulation wrapper instantiates it next to the device and calls $finish on finish; the block itself is synthesizable RTL.

## Interface
- N_SRC, 2, number of finish/fail source channels (1..32)
- MODE_ALL, 1, 1: trigger when every source has finished; 0: trigger when any source has finished
- DRAIN_CYCLES, 16, cycles between trigger and finish, letting in-flight traffic settle; 0 allowed
- TIMEOUT_CYCLES, 1000000, watchdog limit in cycles after reset; 0 disables the watchdog
- CNT_W, 32, width of cycle_count
- sys_clk  in  1  single clock for all logic
- sys_rst  in  1  synchronous, active-high reset
- src_finish  in  N_SRC  per-source finish flag; a level or a pulse is accepted
- src_fail  in  N_SRC  per-source failure flag; a level or a pulse is accepted
- src_seen  out  N_SRC  sticky record of src_finish; reset 0
- fail_seen  out  N_SRC  sticky record of src_fail; reset 0
- finish  out  1  sticky; high in DONE; reset 0
- status  out  2  0 RUNNING, 1 PASS, 2 FAIL, 3 TIMEOUT; reset 0
- cycle_count  out  CNT_W  cycles since reset, frozen in DONE, saturating at all-ones; reset 0

## Operation
- States: RUN, DRAIN, DONE. Reset state is RUN, and sys_rst in any state returns the block to RUN with every output at 0.
- src_seen_nxt = src_seen | src_finish, updated in RUN and DRAIN.
- fail_seen_nxt = fail_seen | src_fail, updated in RUN and DRAIN.
- Both sticky registers freeze in DONE.
- trigger = MODE_ALL ? &src_seen_nxt : |src_seen_nxt, evaluated in RUN only.
- RUN, trigger high:
  - DRAIN_CYCLES > 0: go to DRAIN and load drain_cnt = DRAIN_CYCLES.
  - DRAIN_CYCLES = 0: go directly to DONE.
- RUN, no trigger, TIMEOUT_CYCLES != 0 and cycle_count == TIMEOUT_CYCLES-1: go to DONE with the timeout flag set.
- Trigger and timeout in the same cycle: trigger wins.
- DRAIN: decrement drain_cnt every cycle; when drain_cnt == 1, go to DONE. The watchdog is inactive in DRAIN.
- DONE entry sets finish = 1 and fixes status:
  - TIMEOUT if entered via the watchdog, regardless of fails;
  - else FAIL if |fail_seen_nxt;
  - else PASS.
- DONE is absorbing until sys_rst.
- cycle_count increments in RUN and DRAIN, holds at 2^CNT_W-1, and freezes in DONE.
- drain_cnt width is $clog2(DRAIN_CYCLES+1), minimum 1.
- Inputs may be X in simulation. An X source counts as not asserted; the implementation compares against 1 explicitly.

## Timing
- Cycle 0 is the first edge with sys_rst low.
- Trigger condition sampled at edge t:
  - src_seen is visible at t+1;
  - state is DRAIN at t+1;
  - finish rises at edge t+1+DRAIN_CYCLES;
  - with DRAIN_CYCLES = 0, finish rises at t+1.
- Watchdog: with no trigger, finish and status = TIMEOUT appear at edge TIMEOUT_CYCLES. cycle_count then reads TIMEOUT_CYCLES and stays there.
- status changes only on the same edge that finish rises; before that it reads 0.
- src_fail captured up to and including the DONE-entry edge affects status. Later fails are ignored.
- Pulse inputs of one cycle are never lost in RUN or DRAIN.

## Structure
- Shared package sim_ctrl_pkg holds:
  - typedef enum logic [1:0] sim_status_t (RUNNING, PASS, FAIL, TIMEOUT);
  - typedef enum logic [1:0] sim_state_t (RUN, DRAIN, DONE).
- Flat implementation in one module; no sub-module is warranted.
- The wrapper-side $finish and X-check stay outside this block.

## Test plan
- N_SRC=2, MODE_ALL=1, DRAIN_CYCLES=4:
  - src_finish[0] pulse at cycle 10, src_finish[1] level from cycle 20 -> src_seen=2'b11 at 21, finish rises at 25, status=PASS.
- Same parameters, MODE_ALL=0:
  - src_finish[1] at cycle 7 -> finish at 12, src_seen=2'b10, status=PASS.
- src_fail[0] one-cycle pulse at 15, trigger at 30, DRAIN_CYCLES=4 -> finish at 35, status=FAIL, fail_seen=2'b01. A src_fail[1] pulse at 40 leaves fail_seen unchanged.
- TIMEOUT_CYCLES=100 with no finish -> finish and status=TIMEOUT at cycle 100, cycle_count frozen at 100.
- TIMEOUT_CYCLES=50, DRAIN_CYCLES=0:
  - full trigger at cycle 49 -> finish at 50, status=PASS (trigger beats timeout).
  - Separately, trigger at 30 with DRAIN_CYCLES=40 -> finish at 71 with no timeout.
- sys_rst asserted mid-DRAIN at cycle 23 -> all outputs 0 at cycle 24. A subsequent trigger restarts the full drain count.
